// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer: takes traps and mret at instruction
// boundaries, owns mepc/mcause/mip, and redirects the PC through a 1-cycle REDIRECT state.
module trap_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pipe <= '0;
        else      pipe <= {pipe[STAGES-2:0], d};
    end

    assign q = pipe[STAGES-1];
endmodule

module trap_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic        is_ecall,
    input  logic        is_ebreak,
    input  logic        is_illegal,
    input  logic        is_mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    input  logic        mstatus_mie,
    input  logic        mstatus_mpie,
    input  logic [31:0] csr_mie,
    input  logic [31:0] csr_mtvec,
    input  logic [11:0] csr_addr,
    input  logic        csr_wr_en,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        commit_kill,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        trap_enter,
    output logic        trap_return
);
    typedef enum logic {RUN, REDIRECT} state_t;

    typedef struct packed {
        logic       mret;
        logic       trap;
        logic       intr;
        logic [3:0] code;
    } trap_dec_t;

    state_t      state, state_nxt;
    trap_dec_t   dec;
    logic [31:0] mepc, mcause, mip, irq_en, trap_base, trap_tgt;
    logic [2:0]  irq_raw, irq_s;
    logic [3:0]  int_code, exc_code;
    logic        int_pend, exc_any;
    logic        unused_inputs;

    // MPIE bookkeeping lives entirely in the CSR file
    assign unused_inputs = mstatus_mpie;

    // {ext, timer, sw}; each level source gets its own synchroniser chain
    assign irq_raw = {irq_ext, irq_timer, irq_sw};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        trap_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (irq_raw[i]),
            .q   (irq_s[i])
        );
    end

    assign mip      = {20'b0, irq_s[2], 3'b0, irq_s[1], 3'b0, irq_s[0], 3'b0};
    assign irq_en   = mip & csr_mie & 32'h0000_0888;
    assign int_pend = mstatus_mie & (|irq_en);
    assign exc_any  = is_illegal | is_ebreak | is_ecall;

    always_comb begin
        if (irq_en[11])     int_code = 4'd11;
        else if (irq_en[3]) int_code = 4'd3;
        else                int_code = 4'd7;
    end

    always_comb begin
        if (is_illegal)     exc_code = 4'd2;
        else if (is_ebreak) exc_code = 4'd3;
        else                exc_code = 4'd11;
    end

    // mret outranks a pending interrupt, which outranks a synchronous exception
    always_comb begin
        dec = '0;
        if (state == RUN && instr_valid) begin
            if (is_mret) begin
                dec.mret = 1'b1;
            end else if (int_pend) begin
                dec.trap = 1'b1;
                dec.intr = 1'b1;
                dec.code = int_code;
            end else if (exc_any) begin
                dec.trap = 1'b1;
                dec.code = exc_code;
            end
        end
    end

    assign trap_base = {csr_mtvec[31:2], 2'b00};
    assign trap_tgt  = (csr_mtvec[1:0] == 2'b01 && dec.intr)
                       ? trap_base + {26'b0, dec.code, 2'b00} : trap_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (dec.mret || dec.trap) state_nxt = REDIRECT;
            REDIRECT: state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        commit_kill    = dec.mret | dec.trap;
        redirect_valid = (state == REDIRECT);
        stall          = (state == REDIRECT);
    end

    // A trap or mret drops any same-cycle CSR write; dec is already zero outside RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mepc        <= RESET_PC;
            mcause      <= '0;
            redirect_pc <= '0;
            trap_enter  <= 1'b0;
            trap_return <= 1'b0;
        end else begin
            trap_enter  <= dec.trap;
            trap_return <= dec.mret;
            if (dec.mret) begin
                redirect_pc <= mepc;
            end else if (dec.trap) begin
                redirect_pc <= trap_tgt;
                mepc        <= pc;
                mcause      <= {dec.intr, 27'b0, dec.code};
            end else if (state == RUN && instr_valid && csr_wr_en) begin
                if (csr_addr == 12'h341) mepc   <= {csr_wdata[31:2], 2'b00};
                if (csr_addr == 12'h342) mcause <= csr_wdata;
            end
        end
    end

    always_comb begin
        case (csr_addr)
            12'h341: csr_rdata = mepc;
            12'h342: csr_rdata = mcause;
            12'h344: csr_rdata = mip;
            default: csr_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios then random traffic, all checked
// against a cycle-level reference model of the trap rules.
module tb_trap_ctrl;
    localparam int          SYNC = 2;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk = 1'b0, rst;
    logic        instr_valid, is_ecall, is_ebreak, is_illegal, is_mret;
    logic        irq_ext, irq_timer, irq_sw, mstatus_mie, mstatus_mpie, csr_wr_en;
    logic [31:0] pc, csr_mie, csr_mtvec, csr_wdata, csr_rdata, redirect_pc;
    logic [11:0] csr_addr;
    logic        commit_kill, stall, redirect_valid, trap_enter, trap_return;

    always #5 clk = ~clk;

    trap_ctrl #(.RESET_PC(RPC), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc),
        .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_illegal(is_illegal), .is_mret(is_mret),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
        .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
        .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_addr(csr_addr),
        .csr_wr_en(csr_wr_en), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .commit_kill(commit_kill), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .trap_enter(trap_enter), .trap_return(trap_return)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: architectural registers plus a history of sampled irq levels
    logic [31:0] m_mepc, m_mcause, m_rpc;
    bit          m_redir, m_enter, m_ret;
    logic [2:0]  hist[$];   // {ext,tmr,sw}, newest first

    task automatic m_reset();
        m_mepc = RPC; m_mcause = '0; m_rpc = '0;
        m_redir = 0; m_enter = 0; m_ret = 0;
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(3'b000);
    endtask

    // The mip bit index of each source equals its cause code
    function automatic logic [31:0] m_mip();
        logic [31:0] v;
        v = '0;
        v[11] = hist[SYNC-1][2];
        v[7]  = hist[SYNC-1][1];
        v[3]  = hist[SYNC-1][0];
        return v;
    endfunction

    function automatic int m_pend_code();
        int prio[3];
        logic [31:0] mip;
        prio = '{11, 3, 7};
        mip  = m_mip();
        if (!mstatus_mie) return -1;
        foreach (prio[i]) if (mip[prio[i]] && csr_mie[prio[i]]) return prio[i];
        return -1;
    endfunction

    task automatic check_outputs();
        logic [31:0] exp_rd;
        bit kill;
        kill = !m_redir && instr_valid &&
               (is_mret || m_pend_code() >= 0 || is_ecall || is_ebreak || is_illegal);
        case (csr_addr)
            12'h341: exp_rd = m_mepc;
            12'h342: exp_rd = m_mcause;
            12'h344: exp_rd = m_mip();
            default: exp_rd = '0;
        endcase
        chk("commit_kill", 32'(commit_kill), 32'(kill));
        chk("csr_rdata", csr_rdata, exp_rd);
        chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        chk("stall", 32'(stall), 32'(m_redir));
        chk("trap_enter", 32'(trap_enter), 32'(m_enter));
        chk("trap_return", 32'(trap_return), 32'(m_ret));
        if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic m_edge();
        int  code, c;
        bit  intr;
        code = m_pend_code();
        intr = (code >= 0);
        if (m_redir) begin
            m_redir = 0; m_enter = 0; m_ret = 0;
        end else begin
            m_enter = 0; m_ret = 0;
            if (instr_valid) begin
                if (is_mret) begin
                    m_rpc = m_mepc; m_ret = 1; m_redir = 1;
                end else if (intr || is_ecall || is_ebreak || is_illegal) begin
                    c = intr ? code : (is_illegal ? 2 : (is_ebreak ? 3 : 11));
                    m_mepc   = pc;
                    m_mcause = (intr ? 32'h8000_0000 : 32'h0) | 32'(c);
                    m_rpc    = csr_mtvec & ~32'h3;
                    if (intr && csr_mtvec[1:0] == 2'b01) m_rpc = m_rpc + 32'(4 * c);
                    m_enter = 1; m_redir = 1;
                end else if (csr_wr_en) begin
                    if (csr_addr == 12'h341) m_mepc = csr_wdata & ~32'h3;
                    if (csr_addr == 12'h342) m_mcause = csr_wdata;
                end
            end
        end
        hist.push_front({irq_ext, irq_timer, irq_sw});
        void'(hist.pop_back());
    endtask

    // Called just after a negedge with inputs already set
    task automatic cyc();
        #1 check_outputs();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        instr_valid = 0; is_ecall = 0; is_ebreak = 0; is_illegal = 0; is_mret = 0;
        csr_wr_en = 0; csr_addr = 12'h000; csr_wdata = '0; pc = '0;
    endtask

    task automatic peek(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        #1 chk(tag, csr_rdata, exp);
    endtask

    task automatic do_reset();
        #2 rst = 0;
        m_reset();
        #1;
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_trap_enter", 32'(trap_enter), 32'd0);
        chk("rst_trap_return", 32'(trap_return), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        logic [11:0] addrs[5];
        int r;
        addrs = '{12'h341, 12'h342, 12'h344, 12'h300, 12'h343};
        rst = 0; idle();
        irq_ext = 0; irq_timer = 0; irq_sw = 0;
        mstatus_mie = 0; mstatus_mpie = 0; csr_mie = '0; csr_mtvec = '0;
        m_reset();
        @(negedge clk); @(negedge clk);
        rst = 1;

        // Quiet after reset
        for (int i = 0; i < 3; i++) begin
            csr_addr = addrs[i];
            cyc();
        end
        peek("reset_mepc", 12'h341, RPC);
        peek("reset_mip", 12'h344, 32'h0);

        // ecall, direct vector
        csr_mtvec = 32'h100; pc = 32'h40; instr_valid = 1; is_ecall = 1;
        #1 chk("ecall_kill", 32'(commit_kill), 32'd1);
        cyc();
        idle();
        #1 chk("ecall_rpc", redirect_pc, 32'h100);
        chk("ecall_enter", 32'(trap_enter), 32'd1);
        cyc();
        peek("ecall_mcause", 12'h342, 32'd11);
        peek("ecall_mepc", 12'h341, 32'h40);
        cyc();

        // Timer interrupt, vectored
        csr_mtvec = 32'h101; mstatus_mie = 1; csr_mie = 32'h80; irq_timer = 1;
        cyc(); cyc();
        pc = 32'h200; instr_valid = 1;
        #1 chk("tmr_kill", 32'(commit_kill), 32'd1);
        cyc();
        idle();
        #1 chk("tmr_rpc", redirect_pc, 32'h11C);
        cyc();
        mstatus_mie = 0;
        peek("tmr_mcause", 12'h342, 32'h8000_0007);
        peek("tmr_mepc", 12'h341, 32'h200);
        cyc();

        // ext beats timer; MIE=0 masks both
        csr_mie = 32'h880; irq_ext = 1; mstatus_mie = 1;
        cyc(); cyc();
        pc = 32'h300; instr_valid = 1;
        cyc();
        idle(); mstatus_mie = 0;
        cyc();
        peek("ext_mcause", 12'h342, 32'h8000_000B);
        pc = 32'h304; instr_valid = 1;
        #1 chk("mie0_nokill", 32'(commit_kill), 32'd0);
        cyc();

        // mepc write then mret with an interrupt pending
        idle(); instr_valid = 1; csr_wr_en = 1; csr_addr = 12'h341; csr_wdata = 32'h1003;
        cyc();
        idle();
        peek("mepc_wr", 12'h341, 32'h1000);
        mstatus_mie = 1; instr_valid = 1; is_mret = 1; csr_wr_en = 1; csr_addr = 12'h342;
        csr_wdata = 32'hDEAD_BEEF;
        #1 chk("mret_kill", 32'(commit_kill), 32'd1);
        cyc();
        idle();
        #1 chk("mret_rpc", redirect_pc, 32'h1000);
        chk("mret_return", 32'(trap_return), 32'd1);
        chk("mret_no_enter", 32'(trap_enter), 32'd0);
        cyc();
        mstatus_mie = 0;
        peek("mret_mcause_kept", 12'h342, 32'h8000_000B);
        cyc();

        // Reset while in REDIRECT
        pc = 32'h80; instr_valid = 1; is_ecall = 1;
        cyc();
        idle();
        do_reset();
        peek("rst_mepc", 12'h341, RPC);
        cyc();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                continue;
            end
            idle();
            instr_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            is_ecall = (r == 0); is_ebreak = (r == 1); is_illegal = (r == 2); is_mret = (r == 3);
            if ($urandom_range(0, 7) == 0) irq_ext = ~irq_ext;
            if ($urandom_range(0, 7) == 0) irq_timer = ~irq_timer;
            if ($urandom_range(0, 7) == 0) irq_sw = ~irq_sw;
            mstatus_mie  = 1'($urandom_range(0, 1));
            mstatus_mpie = 1'($urandom_range(0, 1));
            csr_mie   = $urandom();
            csr_mtvec = $urandom();
            pc        = $urandom();
            csr_addr  = addrs[$urandom_range(0, 4)];
            csr_wr_en = ($urandom_range(0, 2) == 0);
            csr_wdata = $urandom();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap and interrupt sequencer for the single-cycle core.
- Consumes the machine CSR state (mstatus.MIE/MPIE, mie, mtvec) and raw interrupt and exception sources.
- Decides trap entry and mret at instruction boundaries and redirects the PC.
- Owns the mepc, mcause and mip registers and exposes them to the CSR read path.

Parameters:
- RESET_PC, 32'h0000_0000, mepc reset value
- SYNC_STAGES, 2, synchroniser depth for asynchronous irq inputs (legal 2..3)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction at pc is being executed this cycle
- pc  in  32  PC of current instruction
- is_ecall / is_ebreak / is_illegal / is_mret  in  1 each  decode flags, mutually exclusive
- irq_ext / irq_timer / irq_sw  in  1 each  level interrupts, asynchronous to clk
- mstatus_mie / mstatus_mpie  in  1 each  from CSR file
- csr_mie  in  32  mie register
- csr_mtvec  in  32  mtvec register
- csr_addr  in  12  CSR address of current instruction
- csr_wr_en  in  1  CSR write strobe
- csr_wdata  in  32  final computed write value
- csr_rdata  out  32  mepc/mcause/mip read data, 0 for other addresses
- commit_kill  out  1  combinational; suppress writeback/memory/PC-increment of current instruction
- stall  out  1  core must hold; high in REDIRECT
- redirect_valid  out  1  PC must load redirect_pc
- redirect_pc  out  32  target PC
- trap_enter  out  1  pulse; CSR file sets MPIE<=MIE, MIE<=0
- trap_return  out  1  pulse; CSR file sets MIE<=MPIE, MPIE<=1

Behaviour:
- Reset (rst=0, async), all outputs registered-low:
  - state=RUN, mepc=RESET_PC, mcause=0, synchroniser flops=0
  - redirect_valid=0, redirect_pc=0, trap_enter=0, trap_return=0, stall=0
- Synchronisers:
  - Each irq passes through SYNC_STAGES flops.
  - mip = {20'b0, ext_s, 3'b0, tmr_s, 3'b0, sw_s, 3'b0}, i.e. bits 11/7/3.
- Pending interrupt:
  - int_pend = mstatus_mie & |(mip & csr_mie & 32'h888).
  - Priority: MEI (code 11) > MSI (3) > MTI (7).
- FSM states: RUN, REDIRECT.
- RUN, instr_valid=1, highest priority first:
  1. is_mret:
     - commit_kill=1.
     - Edge: redirect_pc<=mepc, trap_return<=1, go REDIRECT.
     - Takes precedence over int_pend; the interrupt is re-evaluated on the next instruction.
  2. int_pend:
     - commit_kill=1.
     - Edge: mepc<=pc, mcause<={1'b1, 27'b0, code}, trap_enter<=1, go REDIRECT.
  3. Exception (is_illegal, is_ebreak, is_ecall):
     - commit_kill=1.
     - Edge: mepc<=pc, mcause=2/3/11 respectively (bit31=0), trap_enter<=1, go REDIRECT.
  4. Otherwise: no action; CSR writes to 0x341/0x342 update mepc ({wdata[31:2], 2'b00}) or mcause (full 32 bits).
- Trap target:
  - base = {csr_mtvec[31:2], 2'b00}.
  - mtvec[1:0]==01 and interrupt: base + (code << 2).
  - Otherwise: base. mtvec[1:0]==1x is treated as direct.
- Writes and kill:
  - Trap or mret in the same cycle as csr_wr_en: the trap update wins and the CSR write is dropped (commit_kill also kills it).
  - mip (0x344) is read-only; writes are ignored.
- REDIRECT:
  - Lasts exactly 1 cycle.
  - redirect_valid=1, stall=1; instr_valid is ignored.
  - trap_enter/trap_return are high only in this cycle.
  - Next state: RUN.
  - Net latency: detection cycle N, redirect at N+1, handler first instruction at N+2.
- instr_valid=0 in RUN: no trap is taken, even when int_pend=1.
- csr_rdata (combinational):
  - 0x341 → mepc, 0x342 → mcause, 0x344 → mip, else 0.
  - Reflects register values before any same-cycle update.
- Reset asserted mid-REDIRECT: immediately returns to RUN with all outputs at reset values; the pending redirect is lost.

Test Plan:
- Reset, then release, with no instructions: mepc=0, mcause=0, redirect_valid=0, csr_rdata(0x344)=0 → all hold.
- mtvec=0x100, pc=0x40, is_ecall → commit_kill=1 at N; redirect_valid=1, redirect_pc=0x100, trap_enter=1 at N+1; mcause=11; mepc=0x40.
- mtvec=0x101, MIE=1, mie=0x80, irq_timer raised → after 2 sync cycles plus the next valid instruction at pc=0x200: redirect_pc=0x11C, mcause=0x8000_0007, mepc=0x200.
- irq_ext and irq_timer both enabled and pending → mcause=0x8000_000B; with MIE=0, no trap occurs and the instruction commits.
- CSR write 0x341 ← 0x1003, then is_mret → csr_rdata(0x341)=0x1000; redirect_pc=0x1000, trap_return=1; a simultaneous int_pend is ignored for that instruction.
- Assert rst during REDIRECT → redirect_valid drops without waiting for a clock; mepc=RESET_PC; state RUN.
